nios_system_input_capture: RTL

- Avalon-MM slave parallel input port. Inverse of the existing output PIOs: external signals (controller buttons, game-state flags) flow in, and the Nios CPU reads them.
- Synchronizes inputs, detects edges into a sticky edge-capture register, and raises a maskable level IRQ to the Nios interrupt controller.
- Zero-wait-state reads; readdata is combinational from address.

---
 rtl/nios_system_input_capture_pkg.sv | 31 +++
 rtl/nios_system_input_capture_if.sv | 14 +
 rtl/nios_system_input_debounce.sv | 46 ++++
 rtl/nios_system_input_capture.sv | 92 +++++++++
 4 files changed

// File: rtl/nios_system_input_capture_pkg.sv
// Shared constants and helpers for the nios_system_input_capture parallel input port.
package nios_system_input_capture_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 16;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Per-bit edge vector; unknown encodings fall back to rising.
    function automatic logic [DATA_W-1:0] detect_edge(
        input int unsigned       edge_type,
        input logic [DATA_W-1:0] filt,
        input logic [DATA_W-1:0] prev
    );
        logic [DATA_W-1:0] res;
        case (edge_type)
            EDGE_FALLING: res = ~filt & prev;
            EDGE_ANY:     res = filt ^ prev;
            default:      res = filt & ~prev;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/nios_system_input_capture_if.sv
// Avalon-MM slave bus bundle for the input capture port.
interface nios_system_input_capture_if;
    import nios_system_input_capture_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/nios_system_input_debounce.sv
// Single-bit stable-count filter; only built with NIOS_SYSTEM_INPUT_DEBOUNCE_EN defined.
`ifdef NIOS_SYSTEM_INPUT_DEBOUNCE_EN
module nios_system_input_debounce
    import nios_system_input_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             filt_q, filt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    // Any sample agreeing with the filtered value restarts the stability count.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (din == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            filt_d = din;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign dout = filt_q;

endmodule
`endif

// File: rtl/nios_system_input_capture.sv
// Avalon-MM parallel input port: sync, edge capture (W1C), maskable level irq.
// Optional per-bit debounce filter enabled by NIOS_SYSTEM_INPUT_DEBOUNCE_EN.
module nios_system_input_capture
    import nios_system_input_capture_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    nios_system_input_capture_if.slave   avs,
    input  logic [WIDTH-1:0]             in_port,
    output logic                         irq
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] wdata_w;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = avs.chipselect & ~avs.write_n;
    assign wdata_w      = avs.writedata[WIDTH-1:0];
    assign unused_wdata = ^avs.writedata;

`ifdef NIOS_SYSTEM_INPUT_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        nios_system_input_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .din   (sync2_q[i]),
            .dout  (filt[i])
        );
    end
`else
    assign filt = sync2_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
        end
    end

    // A newly detected edge overrides a same-cycle write-1-to-clear on that bit.
    always_comb begin
        sync1_d    = in_port;
        sync2_d    = sync1_q;
        prev_d     = filt;
        edge_vec   = WIDTH'(detect_edge(EDGE_TYPE, DATA_W'(filt), DATA_W'(prev_q)));
        irq_mask_d = irq_mask_q;
        edge_cap_d = edge_cap_q;
        if (wr_en && (avs.address == ADDR_IRQMASK)) begin
            irq_mask_d = wdata_w;
        end
        if (wr_en && (avs.address == ADDR_EDGECAP)) begin
            edge_cap_d = edge_cap_q & ~wdata_w;
        end
        edge_cap_d = edge_cap_d | edge_vec;
    end

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_DATA:    avs.readdata = DATA_W'(filt);
            ADDR_IRQMASK: avs.readdata = DATA_W'(irq_mask_q);
            ADDR_EDGECAP: avs.readdata = DATA_W'(edge_cap_q);
            default:      avs.readdata = '0;
        endcase
    end

    assign irq = |(edge_cap_q & irq_mask_q);

endmodule
